// File: rtl/lsu_pkg.sv
// Shared types and request-classification helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITEBACK,
    ST_RESP
  } lsu_state_t;

  function automatic logic is_load(input lsu_op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extract+extend for loads, lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = mem_word[{lane, 3'b000} +: 8];
    half_sel    = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data   = mem_word;
    merged_word = mem_word;
    case (op)
      OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_data = {24'd0, byte_sel};
      OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_data = {16'd0, half_sel};
      OP_SB:  merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
      OP_SH: begin
        if (lane[1]) merged_word[31:16] = store_data[15:0];
        else         merged_word[15:0]  = store_data[15:0];
      end
      OP_SW:  merged_word = store_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator; sub-word stores use read-modify-write.
// Define LSU_PERF_EN to add load_count/store_count performance counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
`endif
);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merged;
  logic              misaligned;

  lsu_byte_lane u_lane (
    .op          (op_q),
    .lane        (addr_q[1:0]),
    .mem_word    (mem_data),
    .store_data  (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merged)
  );

  assign misaligned  = is_misaligned(op_q, addr_q[1:0]);
  assign mem_address = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    merged_d       = merged_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = lsu_op_t'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (misaligned) begin
          err_d = 1'b1;
        end else if (is_load(op_q)) begin
          rdata_d = lane_load;
        end else if (op_q == OP_SW) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
        end else begin
          // Sub-word store: hold the merged word for the write cycle.
          merged_d = lane_merged;
          state_d  = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        mem_write      = 1'b1;
        mem_write_data = merged_q;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LB;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

`ifdef LSU_PERF_EN
  logic [31:0] load_count_q, load_count_d;
  logic [31:0] store_count_q, store_count_d;

  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    if (state_q == ST_RESP && !err_q) begin
      if (is_load(op_q))       load_count_d  = load_count_q + 32'd1;
      else if (is_store(op_q)) store_count_d = store_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign load_count  = load_count_q;
  assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-level reference model plus per-cycle compare process.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                         LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data;
`ifdef LSU_PERF_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_data       (mem_data)
`ifdef LSU_PERF_EN
    ,
    .load_count     (load_count),
    .store_count    (store_count)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, whole-word write on posedge.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  assign mem_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outcome of the current transaction
  logic [31:0] exp_rdata, exp_wword, exp_addr;
  logic        exp_err;
  int          exp_lat, exp_nwr;
  int          mdl_loads = 0, mdl_stores = 0;

  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] word, b, h;
    logic        mis;
    word = ref_mem[addr[7:2]];
    b    = (word >> (8 * addr[1:0])) & 32'hFF;
    h    = (word >> (16 * addr[1])) & 32'hFFFF;
    mis  = ((op == LH || op == LHU || op == SH) && addr[0]) ||
           ((op == LW || op == SW) && addr[1:0] != 2'b00);
    exp_err   = mis;
    exp_rdata = 32'h0;
    exp_wword = 32'h0;
    exp_nwr   = 0;
    exp_lat   = 2;
    exp_addr  = addr & ~32'h3;
    if (!mis) begin
      case (op)
        LB:  exp_rdata = (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
        LBU: exp_rdata = b;
        LH:  exp_rdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
        LHU: exp_rdata = h;
        LW:  exp_rdata = word;
        SB: begin
          exp_wword = (word & ~(32'hFF << (8 * addr[1:0]))) | ((wdata & 32'hFF) << (8 * addr[1:0]));
          exp_nwr = 1; exp_lat = 3;
        end
        SH: begin
          exp_wword = (word & ~(32'hFFFF << (16 * addr[1]))) | ((wdata & 32'hFFFF) << (16 * addr[1]));
          exp_nwr = 1; exp_lat = 3;
        end
        default: begin exp_wword = wdata; exp_nwr = 1; end
      endcase
      if (exp_nwr != 0) begin
        ref_mem[addr[7:2]] = exp_wword;
        mdl_stores++;
      end else begin
        mdl_loads++;
      end
    end
  endtask

  // Compare process state
  bit          chk_en = 1'b0;
  bit          txn_active = 1'b0;
  int          k, wr_cnt;
  logic [31:0] got_rdata, got_wword;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (txn_active) begin
        k++;
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (mem_write) begin
          wr_cnt++;
          got_wword = mem_write_data;
          chk("mem_address", mem_address, exp_addr);
        end
        if (k == exp_lat) begin
          chk("resp_valid", {31'd0, resp_valid}, 32'd1);
          chk("resp_rdata", resp_rdata, exp_rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
          chk("write_count", 32'(wr_cnt), 32'(exp_nwr));
          if (exp_nwr != 0) chk("mem_write_data", got_wword, exp_wword);
          got_rdata  = resp_rdata;
          txn_active = 1'b0;
        end else begin
          chk("resp_valid_early", {31'd0, resp_valid}, 32'd0);
        end
      end else begin
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit pin_en, input logic [31:0] pin);
    model(op, addr, wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    got_wword = 32'h0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    k          = 0;
    wr_cnt     = 0;
    txn_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (!txn_active) break;
    end
    if (txn_active) begin
      chk("timeout", 32'd1, 32'd0);
      txn_active = 1'b0;
    end
    if (pin_en) chk("pinned", (exp_nwr != 0) ? got_wword : got_rdata, pin);
    $display("txn op=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h wword=0x%08h err=%0d writes=%0d",
             op, addr, wdata, got_rdata, got_wword, exp_err, wr_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h01010101 * i;
      ref_mem[i] = 32'h01010101 * i;
    end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_req(LB,  32'h13, 32'h0, 1, 32'hFFFFFF88);
    do_req(LHU, 32'h12, 32'h0, 1, 32'h00008899);
    do_req(LW,  32'h10, 32'h0, 1, 32'h8899AABB);
    do_req(SB,  32'h21, 32'h000000EE, 1, 32'h1122EE44);
    do_req(LW,  32'h06, 32'h0, 1, 32'h0);
    do_req(LBU, 32'h10, 32'h0, 1, 32'h000000BB);
    do_req(LH,  32'h10, 32'h0, 1, 32'hFFFFAABB);
    do_req(LH,  32'h12, 32'h0, 1, 32'hFFFF8899);
    do_req(LB,  32'h11, 32'h0, 1, 32'hFFFFFFAA);
    do_req(LBU, 32'h13, 32'h0, 1, 32'h00000088);
    do_req(SH,  32'h22, 32'hABCD5566, 1, 32'h5566EE44);
    do_req(LW,  32'h20, 32'h0, 1, 32'h5566EE44);
    do_req(SW,  32'h24, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    do_req(LH,  32'h24, 32'h0, 1, 32'hFFFFBEEF);
    do_req(LHU, 32'h26, 32'h0, 1, 32'h0000DEAD);
    do_req(SH,  32'h23, 32'h12345678, 0, 32'h0);
    do_req(LHU, 32'h11, 32'h0, 0, 32'h0);
    do_req(SW,  32'h22, 32'hCAFEF00D, 0, 32'h0);
    do_req(LB,  32'h23, 32'h0, 1, 32'h00000055);
    do_req(SB,  32'h30, 32'h000000F0, 0, 32'h0);
    do_req(LB,  32'h30, 32'h0, 1, 32'hFFFFFFF0);

    // Reset in the middle of an SH writeback must not disturb memory.
    chk_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = SH; req_addr = 32'h20; req_wdata = 32'h00007777;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_access_no_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    chk("abort_writeback_write", {31'd0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_write_drop", {31'd0, mem_write}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_unchanged", mem[8], 32'h5566EE44);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    chk("abort_rdata_cleared", resp_rdata, 32'h0);
    chk_en = 1'b1;

    do_req(LW, 32'h20, 32'h0, 1, 32'h5566EE44);

`ifdef LSU_PERF_EN
    // Counters were cleared by the abort reset; one LW has completed since.
    @(negedge clk);
    mdl_loads = 1; mdl_stores = 0;
    do_req(LBU, 32'h12, 32'h0, 0, 32'h0);
    do_req(LW,  32'h24, 32'h0, 0, 32'h0);
    do_req(SB,  32'h28, 32'h11, 0, 32'h0);
    do_req(SW,  32'h2C, 32'h22, 0, 32'h0);
    do_req(LH,  32'h31, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("load_count", load_count, 32'd3);
    chk("store_count", store_count, 32'd2);
    chk("load_count_model", load_count, 32'(mdl_loads));
    chk("store_count_model", store_count, 32'(mdl_stores));
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
